reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/core_pkg.sv | 26 ++
 rtl/word_ser.sv | 39 +++
 rtl/reg_dump.sv | 104 ++++++++++
 tb/tb_reg_dump.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the register dump block: FSM states and word counts.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PC_REQ,
    PC_CAP,
    RD_REQ,
    RD_CAP,
    SEND,
    DONE
  } dump_state_t;

  // Words in a full dump: the PC word plus 32 integer registers,
  // optionally followed by 32 FP registers.
  localparam int WORDS_INT = 33;
  localparam int WORDS_ALL = 65;

  // Register index of the final word; the PC word is not counted in idx.
  function automatic logic [5:0] last_idx(input int words_fp);
    int words;
    words = (words_fp != 0) ? WORDS_ALL : WORDS_INT;
    return 6'(words - 2);
  endfunction

endpackage

// File: rtl/word_ser.sv
// Serializes one 32-bit word into four bytes, LSB first, over a valid/ready link.
module word_ser (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        word_sent
);

  logic [31:0] word;
  logic [1:0]  byte_cnt;
  logic        accept;

  assign accept    = tx_valid && tx_ready;
  assign word_sent = accept && (byte_cnt == 2'd3);
  assign tx_data   = word[{byte_cnt, 3'b000} +: 8];

  // Load a fresh word and hold each byte until the sink takes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word     <= '0;
      byte_cnt <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      word     <= load_word;
      byte_cnt <= '0;
      tx_valid <= 1'b1;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      if (byte_cnt == 2'd3) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_dump.sv
// Dumps the PC and the register file(s) of a core as a byte stream.
module reg_dump
  import core_pkg::*;
#(
  parameter int WORDS_FP = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pcread,
  input  logic [31:0] pc,
  output logic        rfmode,
  output logic [4:0]  rreg1,
  input  logic [31:0] reg_out1,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [5:0] LAST_IDX = last_idx(WORDS_FP);

  dump_state_t state;
  logic [5:0]  idx;
  logic        pc_word;
  logic        load;
  logic [31:0] load_word;
  logic        word_sent;

  assign load      = (state == PC_CAP) || (state == RD_CAP);
  assign load_word = (state == PC_CAP) ? pc : reg_out1;

  word_ser u_ser (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .load_word (load_word),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .word_sent (word_sent)
  );

  // Sequence PC capture, register reads and word sends; outputs are registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      idx     <= '0;
      pc_word <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pcread  <= 1'b0;
      rreg1   <= '0;
      rfmode  <= 1'b0;
    end else begin
      done   <= 1'b0;
      pcread <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PC_REQ;
            busy    <= 1'b1;
            pcread  <= 1'b1;
            idx     <= '0;
            pc_word <= 1'b1;
          end
        end
        PC_REQ: state <= PC_CAP;
        PC_CAP: state <= SEND;
        RD_REQ: state <= RD_CAP;
        RD_CAP: begin
          state  <= SEND;
          rreg1  <= '0;
          rfmode <= 1'b0;
        end
        SEND: begin
          if (word_sent) begin
            if (pc_word) begin
              pc_word <= 1'b0;
              state   <= RD_REQ;
              rreg1   <= idx[4:0];
              rfmode  <= idx[5];
            end else if (idx == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx    <= idx + 6'd1;
              state  <= RD_REQ;
              rreg1  <= 5'(idx + 6'd1);
              rfmode <= idx[5] | (&idx[4:0]);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: one instance with FP dump, one without.
module tb_reg_dump;

  logic        clk;
  logic        rstn;
  logic [1:0]  start;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  pcread;
  logic [1:0]  rfmode;
  logic [1:0]  tx_valid;
  logic [1:0]  tx_ready;
  logic [4:0]  rreg1 [2];
  logic [31:0] reg_out1 [2];
  logic [7:0]  tx_data [2];
  logic [31:0] pc;

  logic [31:0] int_rf [32];
  logic [31:0] fp_rf [32];

  logic [7:0]  exp_q[$];
  logic [7:0]  got[$];
  logic [7:0]  log_a[$];

  int total = 0;
  int bad = 0;
  int sel = 1;
  int byte_cnt = 0;
  int done_cnt = 0;
  bit stall_mode = 0;
  bit stalled = 0;
  bit expect_done = 0;
  bit seen_fp0 = 0;
  bit seen_f31 = 0;
  logic [7:0] held;

  reg_dump #(.WORDS_FP(1)) dut_fp (
    .clk(clk), .rstn(rstn), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pcread(pcread[1]), .pc(pc), .rfmode(rfmode[1]), .rreg1(rreg1[1]),
    .reg_out1(reg_out1[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1])
  );

  reg_dump #(.WORDS_FP(0)) dut_int (
    .clk(clk), .rstn(rstn), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pcread(pcread[0]), .pc(pc), .rfmode(rfmode[0]), .rreg1(rreg1[0]),
    .reg_out1(reg_out1[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0])
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Core register file with a one-cycle read latency.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      reg_out1[d] <= rfmode[d] ? fp_rf[rreg1[d]] : int_rf[rreg1[d]];
  end

  // Sink readiness: always ready, or random stalls.
  initial begin
    tx_ready = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = stall_mode ? 2'($urandom) : 2'b11;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor: pop expected bytes on each accepted transfer, check hold and done.
  always @(negedge clk) begin
    if (rfmode[0]) seen_fp0 = 1;
    if (rfmode[1] && rreg1[1] == 5'd31) seen_f31 = 1;
    if (!rstn) begin
      stalled = 0;
      expect_done = 0;
    end else begin
      if (stalled && tx_valid[sel])
        check_output("hold_data", 32'(tx_data[sel]), 32'(held));
      stalled = tx_valid[sel] && !tx_ready[sel];
      held = tx_data[sel];
      if (done[sel] || expect_done) begin
        check_output("done_timing", 32'(done[sel]), 32'(expect_done));
        if (done[sel]) done_cnt++;
      end
      expect_done = 0;
      if (tx_valid[sel] && tx_ready[sel]) begin
        if (exp_q.size() == 0) begin
          check_output("extra_byte", 32'(tx_data[sel]), 32'hFFFF_FFFF);
        end else begin
          check_output("byte", 32'(tx_data[sel]), 32'(exp_q.pop_front()));
          if (exp_q.size() == 0) expect_done = 1;
        end
        got.push_back(tx_data[sel]);
        byte_cnt++;
      end
    end
  end

  // Reference model: PC word, then registers in index order, LSB first.
  task automatic push_expected(input int words);
    logic [31:0] w;
    for (int i = 0; i < words; i++) begin
      if (i == 0) w = pc;
      else if (i <= 32) w = int_rf[i - 1];
      else w = fp_rf[i - 33];
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  function automatic logic [31:0] word_at(input int n);
    if (got.size() < 4*n + 4) return 32'h0;
    return {got[4*n+3], got[4*n+2], got[4*n+1], got[4*n]};
  endfunction

  task automatic pulse_start(input int d);
    @(posedge clk); #1;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic apply_stimulus(input int d, input int words);
    sel = d;
    got.delete();
    byte_cnt = 0;
    done_cnt = 0;
    seen_fp0 = 0;
    seen_f31 = 0;
    push_expected(words);
    pulse_start(d);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    check_output("done_seen", 32'(done_cnt > 0), 32'd1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int k = 0;
    while (byte_cnt < n && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    check_output("reach_bytes", 32'(byte_cnt >= n), 32'd1);
  endtask

  task automatic check_zero(input int d);
    check_output("rst_busy", 32'(busy[d]), 32'd0);
    check_output("rst_done", 32'(done[d]), 32'd0);
    check_output("rst_pcread", 32'(pcread[d]), 32'd0);
    check_output("rst_tx_valid", 32'(tx_valid[d]), 32'd0);
    check_output("rst_tx_data", 32'(tx_data[d]), 32'd0);
    check_output("rst_rreg1", 32'(rreg1[d]), 32'd0);
    check_output("rst_rfmode", 32'(rfmode[d]), 32'd0);
  endtask

  initial begin
    int diff;
    start = 2'b00;
    rstn = 1'b0;
    pc = 32'h0000_1234;
    for (int i = 0; i < 32; i++) begin
      int_rf[i] = $urandom;
      fp_rf[i] = $urandom;
    end
    int_rf[5] = 32'hDEAD_BEEF;
    fp_rf[31] = 32'h3F80_0000;

    repeat (3) @(posedge clk);
    #1;
    check_zero(1);
    check_zero(0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] full FP dump, sink always ready");
    stall_mode = 0;
    apply_stimulus(1, 65);
    wait_done(2000);
    check_output("a_bytes", 32'(byte_cnt), 32'd260);
    check_output("a_pc_word", word_at(0), 32'h0000_1234);
    check_output("a_x5_word", word_at(6), 32'hDEAD_BEEF);
    check_output("a_f31_word", word_at(64), 32'h3F80_0000);
    check_output("a_f31_read", 32'(seen_f31), 32'd1);
    check_output("a_done_count", 32'(done_cnt), 32'd1);
    check_output("a_busy_after", 32'(busy[1]), 32'd0);
    log_a = got;

    $display("[TB] full FP dump, random stalls");
    stall_mode = 1;
    apply_stimulus(1, 65);
    wait_done(4000);
    check_output("b_bytes", 32'(byte_cnt), 32'd260);
    diff = 0;
    if (got.size() != log_a.size()) diff = 1;
    else foreach (got[i]) if (got[i] !== log_a[i]) diff++;
    check_output("b_same_stream", 32'(diff), 32'd0);
    check_output("b_done_count", 32'(done_cnt), 32'd1);

    $display("[TB] integer-only dump");
    apply_stimulus(0, 33);
    wait_done(3000);
    check_output("c_bytes", 32'(byte_cnt), 32'd132);
    check_output("c_no_fp", 32'(seen_fp0), 32'd0);
    check_output("c_pc_word", word_at(0), 32'h0000_1234);
    check_output("c_last_word", word_at(32), int_rf[31]);
    check_output("c_done_count", 32'(done_cnt), 32'd1);

    $display("[TB] start while busy");
    apply_stimulus(1, 65);
    wait_bytes(100, 1000);
    pulse_start(1);
    wait_done(4000);
    check_output("d_bytes", 32'(byte_cnt), 32'd260);
    check_output("d_done_count", 32'(done_cnt), 32'd1);
    check_output("d_busy_after", 32'(busy[1]), 32'd0);

    $display("[TB] reset mid-dump then restart");
    apply_stimulus(1, 65);
    wait_bytes(50, 1000);
    @(posedge clk); #1;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check_zero(1);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_output("e_no_done", 32'(done_cnt), 32'd0);
    apply_stimulus(1, 65);
    wait_done(4000);
    check_output("e_pc_word", word_at(0), 32'h0000_1234);
    check_output("e_bytes", 32'(byte_cnt), 32'd260);
    check_output("e_done_count", 32'(done_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
